// File: rtl/cam_match_iter_pe_lsb.sv
// LSB-first priority encoder: reports the lowest set bit of req.
// bin is 0 when no bit is set; vld says whether any bit was set.
module pe_lsb #(
   parameter int CDEP = 64,
   localparam int AW = $clog2(CDEP)
) (
   input  logic [CDEP-1:0] req,
   output logic [AW-1:0]   bin,
   output logic            vld
);

   // Scan from the top down so the lowest set index is written last and wins.
   always_comb begin
      bin = '0;
      vld = 1'b0;
      for (int i = CDEP - 1; i >= 0; i--) begin
         if (req[i]) begin
            bin = AW'(i);
            vld = 1'b1;
         end
      end
   end

endmodule

// File: rtl/cam_match_iter.sv
// Multi-match iterator: captures one CAM match vector and streams every matching
// address, lowest first, one per accepted beat; an empty vector yields one miss beat.
module cam_match_iter #(
   parameter int CDEP = 64,
   localparam int AW = $clog2(CDEP)
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            in_vld,
   output logic            in_rdy,
   input  logic [CDEP-1:0] in_match,
   output logic            out_vld,
   input  logic            out_rdy,
   output logic [AW-1:0]   out_addr,
   output logic            out_hit,
   output logic            out_last,
   output logic [AW:0]     out_cnt,
   output logic            busy
);

   localparam logic IDLE = 1'b0;
   localparam logic EMIT = 1'b1;

   function automatic logic [AW:0] popcount(input logic [CDEP-1:0] v);
      logic [AW:0] c;
      c = '0;
      for (int i = 0; i < CDEP; i++) begin
         c = c + {{AW{1'b0}}, v[i]};
      end
      return c;
   endfunction

   logic            state_reg;
   logic [CDEP-1:0] pend_reg;
   logic [CDEP-1:0] clr_onehot;
   logic [CDEP-1:0] pend_next;
   logic [CDEP-1:0] enc_req;
   logic [AW-1:0]   enc_bin;
   logic            enc_vld;
   logic [AW:0]     load_cnt;

   // pend_next is what pend becomes once the current beat is consumed; the
   // single encoder looks ahead at it so the next address is ready without a gap.
   assign clr_onehot = {{(CDEP-1){1'b0}}, 1'b1} << out_addr;
   assign pend_next  = pend_reg & ~clr_onehot;
   assign enc_req    = (state_reg == IDLE) ? in_match : pend_next;
   assign load_cnt   = popcount(in_match);

   pe_lsb #(.CDEP(CDEP)) u_pe (
      .req (enc_req),
      .bin (enc_bin),
      .vld (enc_vld)
   );

   assign in_rdy  = (state_reg == IDLE);
   assign busy    = (state_reg == EMIT);
   assign out_vld = (state_reg == EMIT);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg <= IDLE;
         pend_reg  <= '0;
         out_addr  <= '0;
         out_hit   <= 1'b0;
         out_last  <= 1'b0;
         out_cnt   <= '0;
      end else begin
         case (state_reg)
            IDLE: begin
               if (in_vld) begin
                  pend_reg  <= in_match;
                  out_addr  <= enc_bin;
                  out_hit   <= enc_vld;
                  out_cnt   <= load_cnt;
                  // A miss (count 0) and a single match both finish in one beat.
                  out_last  <= (load_cnt <= (AW+1)'(1));
                  state_reg <= EMIT;
               end
            end
            EMIT: begin
               if (out_rdy) begin
                  pend_reg <= pend_next;
                  if (out_last) begin
                     state_reg <= IDLE;
                     out_addr  <= '0;
                     out_hit   <= 1'b0;
                     out_last  <= 1'b0;
                     out_cnt   <= '0;
                  end else begin
                     out_addr <= enc_bin;
                     out_hit  <= 1'b1;
                     out_cnt  <= out_cnt - (AW+1)'(1);
                     out_last <= (out_cnt == (AW+1)'(2));
                  end
               end
            end
            default: state_reg <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_cam_match_iter.sv
// Self-checking bench for cam_match_iter: directed boundary cases plus randomized
// vectors and back-pressure, checked against a list-of-set-bits reference model.
module tb_cam_match_iter;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_vld;
   logic        in_rdy;
   logic [63:0] in_match;
   logic        out_vld;
   logic        out_rdy;
   logic [5:0]  out_addr;
   logic        out_hit;
   logic        out_last;
   logic [6:0]  out_cnt;
   logic        busy;

   int checks   = 0;
   int failures = 0;

   cam_match_iter #(.CDEP(64)) dut (
      .clk      (clk),
      .rst      (rst),
      .in_vld   (in_vld),
      .in_rdy   (in_rdy),
      .in_match (in_match),
      .out_vld  (out_vld),
      .out_rdy  (out_rdy),
      .out_addr (out_addr),
      .out_hit  (out_hit),
      .out_last (out_last),
      .out_cnt  (out_cnt),
      .busy     (busy)
   );

   always #5 clk = ~clk;

   // Feeds one vector and checks every beat against the ascending list of set
   // bits. mode: 0 = out_rdy always 1, 1 = random 60%, 2 = pattern 1,0,0,1.
   // With hold_b, vector b is presented on in_vld for the whole of this vector.
   task automatic run_vector(input logic [63:0] m, input int mode,
                             input bit hold_b, input logic [63:0] b);
      int         q[$];
      int         total, k, cyc, wt;
      logic [5:0] exp_addr;
      logic       exp_hit, exp_last;
      logic [6:0] exp_cnt;
      for (int i = 0; i < 64; i++) if (m[i]) q.push_back(i);
      wt = 0;
      while (in_rdy !== 1'b1 && wt < 50) begin
         @(posedge clk); #1; wt++;
      end
      checks++;
      if (in_rdy !== 1'b1) begin
         failures++;
         $display("FAIL in_rdy_wait got=%b exp=1", in_rdy);
      end
      in_vld = 1'b1;
      in_match = m;
      @(posedge clk); #1;
      if (hold_b) begin
         in_vld = 1'b1;
         in_match = b;
      end else begin
         in_vld = 1'b0;
         in_match = {$urandom, $urandom};
      end
      checks++;
      if (in_rdy !== 1'b0 || busy !== 1'b1) begin
         failures++;
         $display("FAIL accept_state in_rdy=%b busy=%b exp in_rdy=0 busy=1", in_rdy, busy);
      end
      total = (q.size() == 0) ? 1 : q.size();
      k = 0;
      cyc = 0;
      while (k < total && cyc < 4000) begin
         exp_addr = (q.size() == 0) ? 6'd0 : 6'(q[k]);
         exp_hit  = (q.size() != 0);
         exp_cnt  = (q.size() == 0) ? 7'd0 : 7'(q.size() - k);
         exp_last = (k == total - 1);
         checks++;
         if ({out_vld, in_rdy, out_addr, out_hit, out_cnt, out_last} !==
             {1'b1, 1'b0, exp_addr, exp_hit, exp_cnt, exp_last}) begin
            failures++;
            $display("FAIL beat vec=%h k=%0d got vld=%b rdy=%b addr=%0d hit=%b cnt=%0d last=%b exp vld=1 rdy=0 addr=%0d hit=%b cnt=%0d last=%b",
                     m, k, out_vld, in_rdy, out_addr, out_hit, out_cnt, out_last,
                     exp_addr, exp_hit, exp_cnt, exp_last);
         end
         case (mode)
            0:       out_rdy = 1'b1;
            1:       out_rdy = ($urandom_range(0, 99) < 60);
            default: out_rdy = ((cyc % 4) == 0) || ((cyc % 4) == 3);
         endcase
         if (out_rdy) k++;
         @(posedge clk); #1;
         cyc++;
      end
      out_rdy = 1'b0;
      checks++;
      if (cyc >= 4000) begin
         failures++;
         $display("FAIL timeout vec=%h beats_seen=%0d exp=%0d", m, k, total);
      end
      checks++;
      if (out_vld !== 1'b0 || in_rdy !== 1'b1 || busy !== 1'b0) begin
         failures++;
         $display("FAIL end_state vec=%h got vld=%b in_rdy=%b busy=%b exp 0,1,0",
                  m, out_vld, in_rdy, busy);
      end
      $display("vec %h beats=%0d cycles=%0d mode=%0d", m, total, cyc, mode);
   endtask

   task automatic test_reset();
      rst = 1'b1;
      in_vld = 1'b0;
      in_match = '0;
      out_rdy = 1'b0;
      #2;
      checks++;
      if ({in_rdy, out_vld, out_addr, out_hit, out_last, out_cnt, busy} !==
          {1'b1, 1'b0, 6'd0, 1'b0, 1'b0, 7'd0, 1'b0}) begin
         failures++;
         $display("FAIL reset got rdy=%b vld=%b addr=%0d hit=%b last=%b cnt=%0d busy=%b exp 1,0,0,0,0,0,0",
                  in_rdy, out_vld, out_addr, out_hit, out_last, out_cnt, busy);
      end
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      @(posedge clk); #1;
      checks++;
      if (out_vld !== 1'b0 || in_rdy !== 1'b1) begin
         failures++;
         $display("FAIL idle_after_reset got vld=%b in_rdy=%b exp 0,1", out_vld, in_rdy);
      end
      $display("reset done");
   endtask

   task automatic test_multi();
      run_vector(64'h0000_0000_0000_0912, 0, 1'b0, 64'h0);
   endtask

   task automatic test_miss();
      run_vector(64'h0, 0, 1'b0, 64'h0);
      run_vector(64'h0, 1, 1'b0, 64'h0);
   endtask

   task automatic test_all_ones();
      run_vector({64{1'b1}}, 0, 1'b0, 64'h0);
   endtask

   task automatic test_top_bit();
      run_vector(64'h8000_0000_0000_0000, 0, 1'b0, 64'h0);
   endtask

   task automatic test_stall();
      run_vector(64'h8000_0000_0000_0001, 2, 1'b0, 64'h0);
   endtask

   task automatic test_back_to_back();
      logic [63:0] b;
      b = 64'h0000_00F0_0000_0300;
      run_vector(64'h0000_0000_0000_0912, 1, 1'b1, b);
      run_vector(b, 0, 1'b0, 64'h0);
   endtask

   task automatic test_reset_mid_emit();
      in_vld = 1'b1;
      in_match = 64'h0000_0000_0000_0912;
      @(posedge clk); #1;
      in_vld = 1'b0;
      checks++;
      if (out_vld !== 1'b1 || out_addr !== 6'd1) begin
         failures++;
         $display("FAIL rst_beat1 got vld=%b addr=%0d exp 1,1", out_vld, out_addr);
      end
      out_rdy = 1'b1;
      @(posedge clk); #1;
      out_rdy = 1'b0;
      checks++;
      if (out_addr !== 6'd4 || out_cnt !== 7'd3) begin
         failures++;
         $display("FAIL rst_beat2 got addr=%0d cnt=%0d exp 4,3", out_addr, out_cnt);
      end
      rst = 1'b1;
      #1;
      checks++;
      if ({out_vld, in_rdy, out_cnt, out_addr, busy} !== {1'b0, 1'b1, 7'd0, 6'd0, 1'b0}) begin
         failures++;
         $display("FAIL async_reset got vld=%b in_rdy=%b cnt=%0d addr=%0d busy=%b exp 0,1,0,0,0",
                  out_vld, in_rdy, out_cnt, out_addr, busy);
      end
      @(posedge clk); #1;
      rst = 1'b0;
      $display("reset mid-emit done");
      run_vector(64'h4, 0, 1'b0, 64'h0);
   endtask

   task automatic test_random();
      logic [63:0] m;
      logic [63:0] one;
      one = 64'd1;
      for (int n = 0; n < 16; n++) begin
         case ($urandom_range(0, 3))
            0:       m = 64'h0;
            1:       m = one << $urandom_range(0, 63);
            2:       m = {$urandom, $urandom} & {$urandom, $urandom} & {$urandom, $urandom};
            default: m = {$urandom, $urandom};
         endcase
         run_vector(m, ($urandom_range(0, 1) == 0) ? 0 : 1, 1'b0, 64'h0);
      end
   endtask

   initial begin
      test_reset();
      test_multi();
      test_miss();
      test_all_ones();
      test_top_bit();
      test_stall();
      test_back_to_back();
      test_reset_mid_emit();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
